// File: rtl/cond_pkg.sv
// Shared condition-code encodings, NZCV flag bit positions and flag typedef.
package cond_pkg;

    localparam logic [3:0] EQ = 4'b0000;
    localparam logic [3:0] NE = 4'b0001;
    localparam logic [3:0] CS = 4'b0010;
    localparam logic [3:0] CC = 4'b0011;
    localparam logic [3:0] MI = 4'b0100;
    localparam logic [3:0] PL = 4'b0101;
    localparam logic [3:0] VS = 4'b0110;
    localparam logic [3:0] VC = 4'b0111;
    localparam logic [3:0] HI = 4'b1000;
    localparam logic [3:0] LS = 4'b1001;
    localparam logic [3:0] GE = 4'b1010;
    localparam logic [3:0] LT = 4'b1011;
    localparam logic [3:0] GT = 4'b1100;
    localparam logic [3:0] LE = 4'b1101;
    localparam logic [3:0] AL = 4'b1110;
    localparam logic [3:0] NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // A lane needs the flags unless its outcome is a constant true.
    function automatic logic flag_dependent(input logic [3:0] cond, input logic nv_true);
        return !((cond == AL) || ((cond == NV) && nv_true));
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Single-lane condition evaluator: cond code against {N,Z,C,V}.
// Purely combinational; no backpressure.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    input  logic       nv_true,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            EQ: pass = z;
            NE: pass = ~z;
            CS: pass = c;
            CC: pass = ~c;
            MI: pass = n;
            PL: pass = ~n;
            VS: pass = v;
            VC: pass = ~v;
            HI: pass = c & ~z;
            LS: pass = ~c | z;
            GE: pass = (n == v);
            LT: pass = (n != v);
            GT: pass = ~z & (n == v);
            LE: pass = z | (n != v);
            AL: pass = 1'b1;
            NV: pass = nv_true;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_cond_unit.sv
// Status-flag register with pending-writer scoreboard and per-lane condition evaluation.
// Latency: one cycle from accepted issue to registered out_valid/out_pass.
// Backpressure: issue stalls on flag hazard, full scoreboard, flush, or held result (out_valid & ~out_ready).
module status_cond_unit
    import cond_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int MAX_PEND = 3,
    parameter int BYPASS   = 1,
    parameter int NV_TRUE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [4*LANES-1:0] issue_cond,
    input  logic               issue_sets_flags,
    input  logic               wb_valid,
    input  logic [3:0]         wb_flags,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES-1:0]   out_pass,
    output logic [3:0]         status
);

    localparam int             CW       = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0]  PEND_MAX = CW'(MAX_PEND);
    localparam logic [CW-1:0]  PEND_ONE = CW'(1);
    localparam logic           BYP      = (BYPASS != 0);
    localparam logic           NVT      = (NV_TRUE != 0);

    flags_t           status_q;
    logic [CW-1:0]    pend_cnt;
    logic [3:0]       eval_flags;
    logic [LANES-1:0] lane_dep;
    logic [LANES-1:0] lane_pass;
    logic             any_dep;
    logic             hazard;
    logic             pend_full;
    logic             accept;
    logic             inc;
    logic             dec;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cond_eval u_eval (
            .cond    (issue_cond[4*i +: 4]),
            .flags   (eval_flags),
            .nv_true (NVT),
            .pass    (lane_pass[i])
        );
        assign lane_dep[i] = flag_dependent(issue_cond[4*i +: 4], NVT);
    end

    assign any_dep    = |lane_dep;
    // A writeback landing this cycle retires the last pending writer and is forwarded.
    assign hazard     = (pend_cnt != '0) & any_dep & ~(BYP & (pend_cnt == PEND_ONE) & wb_valid);
    assign pend_full  = issue_sets_flags & (pend_cnt == PEND_MAX) & ~wb_valid;
    assign issue_ready = ~hazard & (~out_valid | out_ready) & ~pend_full & ~flush;
    assign accept     = issue_valid & issue_ready;
    assign eval_flags = (BYP & wb_valid) ? wb_flags : status_q;
    assign inc        = accept & issue_sets_flags;
    assign dec        = wb_valid & (pend_cnt != '0);
    assign status     = status_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else if (wb_valid) begin
            status_q <= wb_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt <= '0;
        end else if (flush) begin
            pend_cnt <= '0;
        end else if (inc && !dec) begin
            pend_cnt <= pend_cnt + PEND_ONE;
        end else if (dec && !inc) begin
            pend_cnt <= pend_cnt - PEND_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pass  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pass  <= lane_pass;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_status_cond_unit.sv
// Directed bench for status_cond_unit with a cycle-level reference model checked on every falling edge.
module tb_status_cond_unit;

    localparam int LANES    = 2;
    localparam int MAX_PEND = 3;
    localparam int BYPASS   = 1;
    localparam int NV_TRUE  = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               issue_valid;
    logic               issue_ready;
    logic [4*LANES-1:0] issue_cond;
    logic               issue_sets_flags;
    logic               wb_valid;
    logic [3:0]         wb_flags;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [LANES-1:0]   out_pass;
    logic [3:0]         status;

    int total = 0;
    int bad   = 0;

    logic [3:0]       m_status;
    int               m_pend;
    logic             m_ov;
    logic [LANES-1:0] m_op;

    status_cond_unit #(
        .LANES(LANES), .MAX_PEND(MAX_PEND), .BYPASS(BYPASS), .NV_TRUE(NV_TRUE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_cond       (issue_cond),
        .issue_sets_flags (issue_sets_flags),
        .wb_valid         (wb_valid),
        .wb_flags         (wb_flags),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pass         (out_pass),
        .status           (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs; bit 0 inverts the base test.
    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] != 3'd7) return base ^ c[0];
        return c[0] ? (NV_TRUE != 0) : 1'b1;
    endfunction

    always @(negedge clk) begin
        logic             needs_flags, wait_flags, out_busy, full, rdy, acc;
        logic [3:0]       f, c;
        logic [LANES-1:0] ev;
        int               p;
        if (rst) begin
            m_status = '0; m_pend = 0; m_ov = 1'b0; m_op = '0;
            check("m_rst_status", status, 0);
            check("m_rst_valid", out_valid, 0);
            check("m_rst_pass", out_pass, 0);
        end else begin
            needs_flags = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                c = issue_cond[4*i +: 4];
                if (!(c == 4'd14 || (c == 4'd15 && NV_TRUE != 0))) needs_flags = 1'b1;
            end
            wait_flags = (m_pend > 0) && needs_flags && !(BYPASS != 0 && m_pend == 1 && wb_valid);
            out_busy   = m_ov && !out_ready;
            full       = issue_sets_flags && (m_pend >= MAX_PEND) && !wb_valid;
            rdy        = !(wait_flags || out_busy || full || flush);
            check("m_ready", issue_ready, rdy);
            check("m_valid", out_valid, m_ov);
            if (m_ov) check("m_pass", out_pass, m_op);
            check("m_status", status, m_status);

            acc = issue_valid && rdy;
            f   = (BYPASS != 0 && wb_valid) ? wb_flags : m_status;
            for (int i = 0; i < LANES; i++) ev[i] = cond_true(issue_cond[4*i +: 4], f);
            if (flush) begin
                m_pend = 0;
                m_ov   = 1'b0;
            end else begin
                p = m_pend;
                if (acc && issue_sets_flags) p++;
                if (wb_valid && m_pend > 0) p--;
                m_pend = p;
                if (acc) begin
                    m_ov = 1'b1;
                    m_op = ev;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end
            if (wb_valid) m_status = wb_flags;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_sets_flags = 1'b0; wb_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        issue_cond = '0;
        wb_flags   = '0;
        tick(); tick();
        check("reset_status", status, 4'h0);
        check("reset_valid", out_valid, 0);
        check("reset_pass", out_pass, 0);
        tick();
        rst = 1'b0;
        wb_valid = 1'b1; wb_flags = 4'b0100;
        #1 check("ready_after_rst", issue_ready, 1);

        // EQ/NE against Z=1
        tick(); idle(); issue_valid = 1'b1; issue_cond = 8'h10;
        #1 check("status_0100", status, 4'b0100);
        check("ready_eq_ne", issue_ready, 1);
        tick(); idle(); issue_valid = 1'b1; issue_sets_flags = 1'b1; issue_cond = 8'hEE;
        #1 check("eq_ne_valid", out_valid, 1);
        check("eq_ne_pass", out_pass, 2'b01);
        check("al_sets_ready", issue_ready, 1);

        // GT waits on the pending writer, then goes on the forwarded writeback
        tick(); idle(); issue_valid = 1'b1; issue_cond = 8'hCC;
        #1 check("gt_stall0", issue_ready, 0);
        tick();
        #1 check("gt_stall1", issue_ready, 0);
        tick(); wb_valid = 1'b1; wb_flags = 4'b0000;
        #1 check("gt_bypass_ready", issue_ready, 1);
        tick(); idle(); issue_valid = 1'b1; issue_cond = 8'hCD; wb_valid = 1'b1; wb_flags = 4'b1000;
        #1 check("gt_pass", out_pass, 2'b11);
        check("gt_valid", out_valid, 1);
        check("gt_status", status, 4'b0000);
        check("le_ready", issue_ready, 1);

        // lane0 LE, lane1 GT across three flag sets
        tick(); wb_flags = 4'b0100;
        #1 check("le_n1", out_pass, 2'b01);
        check("status_1000", status, 4'b1000);
        tick(); wb_flags = 4'b0000;
        #1 check("le_z1", out_pass, 2'b01);
        tick(); idle(); wb_valid = 1'b1; wb_flags = 4'b1001;
        #1 check("le_zero", out_pass, 2'b10);
        tick(); idle(); issue_valid = 1'b1; issue_cond = 8'hCD;
        #1 check("status_1001", status, 4'b1001);
        tick(); idle();
        #1 check("status_path_pass", out_pass, 2'b10);

        // result held under backpressure
        tick(); idle(); issue_valid = 1'b1; issue_cond = 8'h42; out_ready = 1'b0;
        #1 check("bp_first_ready", issue_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick(); issue_valid = 1'b1; issue_cond = 8'h01; out_ready = 1'b0;
            #1 check("hold_valid", out_valid, 1);
            check("hold_pass", out_pass, 2'b10);
            check("hold_ready", issue_ready, 0);
        end
        tick(); out_ready = 1'b1;
        #1 check("release_ready", issue_ready, 1);
        check("release_old_pass", out_pass, 2'b10);
        tick(); idle();
        #1 check("release_pass", out_pass, 2'b01);

        // fill the scoreboard
        issue_valid = 1'b1; issue_sets_flags = 1'b1; issue_cond = 8'hEE;
        #1 check("fill0", issue_ready, 1);
        tick();
        #1 check("fill1", issue_ready, 1);
        tick();
        #1 check("fill2", issue_ready, 1);
        tick();
        #1 check("full_stall", issue_ready, 0);
        tick(); wb_valid = 1'b1; wb_flags = 4'b0010;
        #1 check("full_wb_ready", issue_ready, 1);
        tick(); idle(); issue_valid = 1'b1; issue_sets_flags = 1'b1; issue_cond = 8'hEE;
        #1 check("still_full", issue_ready, 0);
        check("status_0010", status, 4'b0010);
        issue_sets_flags = 1'b0; wb_valid = 1'b1; wb_flags = 4'b0010;
        #1 check("al_at_full_ready", issue_ready, 1);

        // flush with two pending and a result held
        tick(); idle(); flush = 1'b1; issue_valid = 1'b1; issue_cond = 8'h00;
        #1 check("flush_ready", issue_ready, 0);
        check("pre_flush_valid", out_valid, 1);
        tick(); idle(); issue_valid = 1'b1; issue_cond = 8'h00;
        #1 check("flush_valid", out_valid, 0);
        check("eq_after_flush", issue_ready, 1);
        tick(); idle(); out_ready = 1'b0;
        #1 check("eq_after_flush_pass", out_pass, 2'b00);
        check("eq_after_flush_valid", out_valid, 1);

        // asynchronous reset in the middle of backpressure
        tick(); out_ready = 1'b0;
        rst = 1'b1;
        #1 check("mid_rst_status", status, 4'h0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_pass", out_pass, 0);
        tick(); rst = 1'b0; idle();
        #1 check("ready_after_mid_rst", issue_ready, 1);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_cond_unit.md
STATUS_COND_UNIT -- requirements
Module: status_cond_unit

Interface
REQ-001 SHALL have parameter LANES, default 2: condition queries evaluated per accepted issue.
REQ-002 SHALL have parameter MAX_PEND, default 3: maximum outstanding flag-setting instructions; counter width is clog2(MAX_PEND+1).
REQ-003 SHALL have parameter BYPASS, default 1: 1 enables same-cycle writeback-to-evaluation forwarding.
REQ-004 SHALL have parameter NV_TRUE, default 1: 1 means cond 1111 evaluates true, 0 means it evaluates false.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- issue_valid  in  1  issue request.
- issue_ready  out  1  issue may be accepted.
- issue_cond  in  4*LANES  condition code per lane; lane i is bits [4i+3:4i].
- issue_sets_flags  in  1  accepted instruction will later write the flags.
- wb_valid  in  1  flag writeback.
- wb_flags  in  4  {N,Z,C,V}.
- flush  in  1  pipeline flush.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_pass  out  LANES  per-lane condition result.
- status  out  4  current {N,Z,C,V} register.

Function
REQ-007 SHALL evaluate each lane as follows: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 NV_TRUE.
REQ-008 SHALL hold the 4-bit status register; wb_valid loads wb_flags at the next edge regardless of the pending count.
REQ-009 SHALL keep pend_cnt: +1 on an accepted issue with issue_sets_flags; -1 on wb_valid when pend_cnt>0; unchanged when both occur in the same cycle; never below 0.
REQ-010 SHALL treat a lane as flag-dependent unless its cond is 1110, or 1111 with NV_TRUE=1.
REQ-011 SHALL assert hazard when pend_cnt!=0 and any lane is flag-dependent; with BYPASS=1, hazard is cleared when pend_cnt==1 and wb_valid is high.
REQ-012 SHALL drive issue_ready = ~hazard & (~out_valid | out_ready) & ~(issue_sets_flags & pend_cnt==MAX_PEND & ~wb_valid) & ~flush.
REQ-013 SHALL evaluate with wb_flags when BYPASS=1 and wb_valid is high in the accept cycle; otherwise it SHALL use the status register.
REQ-014 SHALL register results: issue accepted in cycle t gives out_valid=1 and out_pass valid in cycle t+1 (latency 1).
REQ-015 SHALL hold out_valid and out_pass stable while out_valid & ~out_ready.
REQ-016 SHALL sustain one issue per cycle under out_ready=1 (pass-through on simultaneous pop and push).
REQ-017 SHALL, on flush, clear pend_cnt and out_valid at the next edge and accept no issue that cycle; the status register still honours a same-cycle wb_valid.
REQ-018 SHALL drive status = status register contents (no bypass).

Reset
REQ-019 SHALL, on rst asserted, immediately set status=0000, pend_cnt=0, out_valid=0 and out_pass=0; this includes mid-hazard and mid-backpressure.
REQ-020 SHALL accept no issue in the first edge after rst deasserts only if issue_ready was low; otherwise issue_ready SHALL be high in the first cycle out of reset.

Structure
REQ-021 SHALL place cond-code localparams (EQ..NV), flag bit indices N=3, Z=2, C=1, V=0, and the flag struct/typedef in shared package cond_pkg.
REQ-022 SHALL use combinational sub-module cond_eval (cond, flags, nv_true -> pass), instantiated LANES times.

Verification
REQ-023 SHALL cover: reset, wb_flags=0100, issue lanes {EQ,NE} -> next cycle out_pass=01 (lane0=1), status=0100.
REQ-024 SHALL cover: issue sets_flags with AL lanes, then issue GT -> stall while pend_cnt=1; wb_flags=0000 with BYPASS=1 -> accepted that cycle, out_pass lane=1.
REQ-025 SHALL cover: LE with N=1, V=0, Z=0 -> 1; with N=V=0, Z=1 -> 1; with N=V=0, Z=0 -> 0.
REQ-026 SHALL cover: out_ready=0 for 3 cycles after a result -> out_valid and out_pass held, issue_ready=0; out_ready=1 -> new issue accepted the same cycle.
REQ-027 SHALL cover: MAX_PEND=3 sets_flags issues -> 4th sets_flags stalls; the same cycle with wb_valid -> accepted, pend_cnt stays 3.
REQ-028 SHALL cover: flush with pend_cnt=2 and out_valid=1 -> next cycle pend_cnt=0 and out_valid=0; an EQ issue is then accepted without stall.
